// File: rtl/pwr_seq_pkg.sv
// Shared types and constants for the power-enable sequencer.
package pwr_seq_pkg;

   localparam int unsigned NUM_MODULES_DEFAULT = 32;

   typedef logic [1:0] mode_t;

   localparam mode_t MODE_STATIC    = 2'd0;
   localparam mode_t MODE_RAMP_UP   = 2'd1;
   localparam mode_t MODE_RAMP_DOWN = 2'd2;
   localparam mode_t MODE_WALK      = 2'd3;

   typedef enum logic {
      IDLE,
      DWELL
   } state_e;

endpackage

// File: rtl/pwr_en_sequencer_if.sv
// Control/status bundle between the run controller and the sequencer.
interface pwr_en_sequencer_if
   import pwr_seq_pkg::*;
#(
   parameter int unsigned NUM_MODULES = NUM_MODULES_DEFAULT,
   parameter int unsigned DWELL_W     = 32,
   parameter int unsigned IDX_W       = 6
);
   logic                   start;
   logic                   abort;
   mode_t                  mode;
   logic [IDX_W-1:0]       step;
   logic [DWELL_W-1:0]     dwell_cycles;
   logic [NUM_MODULES-1:0] static_mask;
   logic [NUM_MODULES-1:0] pwr_en_out;
   logic                   busy;
   logic                   done;
   logic [IDX_W-1:0]       step_idx;
   logic                   marker;

   modport master (
      output start, abort, mode, step, dwell_cycles, static_mask,
      input  pwr_en_out, busy, done, step_idx, marker
   );

   modport slave (
      input  start, abort, mode, step, dwell_cycles, static_mask,
      output pwr_en_out, busy, done, step_idx, marker
   );
endinterface

// File: rtl/pwr_mask_gen.sv
// Maps (mode, level) to an enable mask: static pattern, thermometer or one-hot.
module pwr_mask_gen
   import pwr_seq_pkg::*;
#(
   parameter int unsigned NUM_MODULES = NUM_MODULES_DEFAULT,
   parameter int unsigned LVL_W       = $clog2(NUM_MODULES + 1)
) (
   input  mode_t                  mode,
   input  logic [LVL_W-1:0]       level,
   input  logic [NUM_MODULES-1:0] static_mask,
   output logic [NUM_MODULES-1:0] mask
);

   // Ramps use the low 'level' bits; walk lights only bit 'level'.
   always_comb begin
      mask = '0;
      case (mode)
         MODE_STATIC: mask = static_mask;
         MODE_RAMP_UP, MODE_RAMP_DOWN: begin
            for (int unsigned i = 0; i < NUM_MODULES; i++) begin
               mask[i] = (level > LVL_W'(i));
            end
         end
         MODE_WALK: begin
            for (int unsigned i = 0; i < NUM_MODULES; i++) begin
               mask[i] = (level == LVL_W'(i));
            end
         end
         default: mask = '0;
      endcase
   end

endmodule

// File: rtl/pwr_en_sequencer.sv
// Steps the DUT power-enable vector through a pattern, holding each level for a dwell.
module pwr_en_sequencer
   import pwr_seq_pkg::*;
#(
   parameter int unsigned NUM_MODULES = NUM_MODULES_DEFAULT,
   parameter int unsigned DWELL_W     = 32,
   parameter int unsigned IDX_W       = 6
) (
   input  logic               clk100m,
   input  logic               rstn,
   pwr_en_sequencer_if.slave  bus
);

   localparam int unsigned LVL_W = $clog2(NUM_MODULES + 1);
   // Wide enough that level + stride cannot wrap before the clamp.
   localparam int unsigned SUM_W = ((LVL_W > IDX_W) ? LVL_W : IDX_W) + 1;
   localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(NUM_MODULES);

   state_e                 state_q, state_d;
   mode_t                  mode_q, mode_d;
   logic [IDX_W-1:0]       stride_q, stride_d;
   logic [DWELL_W-1:0]     dwell_q, dwell_d;
   logic [DWELL_W-1:0]     cnt_q, cnt_d;
   logic [NUM_MODULES-1:0] smask_q, smask_d;
   logic [LVL_W-1:0]       level_q, level_d;
   logic [NUM_MODULES-1:0] out_q, out_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic                   marker_q, marker_d;

   logic [SUM_W-1:0]       sum;
   logic [LVL_W-1:0]       level_next;
   logic                   last_level;
   mode_t                  gen_mode;
   logic [LVL_W-1:0]       gen_level;
   logic [NUM_MODULES-1:0] gen_smask;
   logic [NUM_MODULES-1:0] gen_mask;

   // Next level for the latched mode, clamped to [0, NUM_MODULES].
   always_comb begin
      sum        = SUM_W'(level_q) + SUM_W'(stride_q);
      level_next = level_q;
      last_level = 1'b1;
      case (mode_q)
         MODE_RAMP_UP: begin
            level_next = (sum >= SUM_W'(NUM_MODULES)) ? LVL_MAX : sum[LVL_W-1:0];
            last_level = (level_q == LVL_MAX);
         end
         MODE_RAMP_DOWN: begin
            level_next = (SUM_W'(level_q) > SUM_W'(stride_q)) ?
                         LVL_W'(SUM_W'(level_q) - SUM_W'(stride_q)) : '0;
            last_level = (level_q == '0);
         end
         MODE_WALK: begin
            level_next = level_q + LVL_W'(1);
            last_level = (level_q == LVL_W'(NUM_MODULES - 1));
         end
         default: begin
            level_next = level_q;
            last_level = 1'b1;
         end
      endcase
   end

   // In IDLE the mask generator sees the live config so the first level loads on start.
   always_comb begin
      gen_mode  = mode_q;
      gen_level = level_next;
      gen_smask = smask_q;
      if (state_q == IDLE) begin
         gen_mode  = bus.mode;
         gen_level = (bus.mode == MODE_RAMP_DOWN) ? LVL_MAX : '0;
         gen_smask = bus.static_mask;
      end
   end

   pwr_mask_gen #(
      .NUM_MODULES (NUM_MODULES),
      .LVL_W       (LVL_W)
   ) u_mask_gen (
      .mode        (gen_mode),
      .level       (gen_level),
      .static_mask (gen_smask),
      .mask        (gen_mask)
   );

   // Next-state and registered-output logic.
   always_comb begin
      state_d  = state_q;
      mode_d   = mode_q;
      stride_d = stride_q;
      dwell_d  = dwell_q;
      cnt_d    = cnt_q;
      smask_d  = smask_q;
      level_d  = level_q;
      out_d    = out_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      idx_d    = idx_q;
      marker_d = marker_q;
      case (state_q)
         IDLE: begin
            if (bus.start && !bus.abort) begin
               mode_d   = bus.mode;
               stride_d = (bus.step == '0) ? IDX_W'(1) : bus.step;
               dwell_d  = (bus.dwell_cycles == '0) ? DWELL_W'(1) : bus.dwell_cycles;
               smask_d  = bus.static_mask;
               level_d  = gen_level;
               out_d    = gen_mask;
               cnt_d    = '0;
               idx_d    = '0;
               marker_d = ~marker_q;
               busy_d   = 1'b1;
               state_d  = DWELL;
            end
         end
         DWELL: begin
            if (bus.abort) begin
               out_d   = '0;
               busy_d  = 1'b0;
               state_d = IDLE;
            end else if (cnt_q == dwell_q - DWELL_W'(1)) begin
               if (last_level) begin
                  out_d   = '0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  level_d  = level_next;
                  out_d    = gen_mask;
                  cnt_d    = '0;
                  idx_d    = idx_q + IDX_W'(1);
                  marker_d = ~marker_q;
               end
            end else begin
               cnt_d = cnt_q + DWELL_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk100m) begin
      if (!rstn) begin
         state_q  <= IDLE;
         mode_q   <= MODE_STATIC;
         stride_q <= '0;
         dwell_q  <= '0;
         cnt_q    <= '0;
         smask_q  <= '0;
         level_q  <= '0;
         out_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         idx_q    <= '0;
         marker_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         mode_q   <= mode_d;
         stride_q <= stride_d;
         dwell_q  <= dwell_d;
         cnt_q    <= cnt_d;
         smask_q  <= smask_d;
         level_q  <= level_d;
         out_q    <= out_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         idx_q    <= idx_d;
         marker_q <= marker_d;
      end
   end

   assign bus.pwr_en_out = out_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.step_idx   = idx_q;
   assign bus.marker     = marker_q;

endmodule

// File: tb/tb_pwr_en_sequencer.sv
// Scoreboard bench: expected per-cycle outputs are queued at start and checked each cycle.
module tb_pwr_en_sequencer;
   import pwr_seq_pkg::*;

   typedef struct {
      logic [31:0] out;
      logic        busy;
      logic        done;
      logic [5:0]  idx;
      logic        marker;
   } exp_t;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   exp_t sb[$];
   logic exp_marker = 1'b0;
   int   n_checks = 0;
   int   n_pass = 0;

   pwr_en_sequencer_if #(.NUM_MODULES(32), .DWELL_W(32), .IDX_W(6)) bus ();

   pwr_en_sequencer #(
      .NUM_MODULES (32),
      .DWELL_W     (32),
      .IDX_W       (6)
   ) dut (
      .clk100m (clk),
      .rstn    (rstn),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
   endtask

   function automatic exp_t mk(logic [31:0] o, logic b, logic d, int i, logic m);
      exp_t e;
      e.out = o; e.busy = b; e.done = d; e.idx = 6'(i); e.marker = m;
      return e;
   endfunction

   function automatic logic [31:0] thermo(int k);
      logic [63:0] t;
      t = (64'd1 << k) - 64'd1;
      return t[31:0];
   endfunction

   // Build the level list from the pattern definition and queue per-cycle expectations.
   task automatic gen(input mode_t m, input int step, input int dwell, input logic [31:0] smask,
                      input int max_lv, input bit add_done);
      logic [31:0] lv[$];
      int s, d, k, n;
      s = (step == 0) ? 1 : step;
      d = (dwell == 0) ? 1 : dwell;
      case (m)
         MODE_STATIC: lv.push_back(smask);
         MODE_RAMP_UP: begin
            k = 0;
            lv.push_back(thermo(0));
            while (k < 32) begin
               k = (k + s > 32) ? 32 : k + s;
               lv.push_back(thermo(k));
            end
         end
         MODE_RAMP_DOWN: begin
            k = 32;
            lv.push_back(thermo(32));
            while (k > 0) begin
               k = (k > s) ? k - s : 0;
               lv.push_back(thermo(k));
            end
         end
         default: for (int w = 0; w < 32; w++) lv.push_back(32'h1 << w);
      endcase
      n = (lv.size() < max_lv) ? lv.size() : max_lv;
      for (int i = 0; i < n; i++) begin
         exp_marker = ~exp_marker;
         for (int j = 0; j < d; j++) sb.push_back(mk(lv[i], 1'b1, 1'b0, i, exp_marker));
      end
      if (add_done) begin
         sb.push_back(mk(32'h0, 1'b0, 1'b1, 0, exp_marker));
         sb.push_back(mk(32'h0, 1'b0, 1'b0, 0, exp_marker));
      end
   endtask

   task automatic cmp(input exp_t e);
      check("pwr_en_out", bus.pwr_en_out, e.out);
      check("busy", 32'(bus.busy), 32'(e.busy));
      check("done", 32'(bus.done), 32'(e.done));
      check("marker", 32'(bus.marker), 32'(e.marker));
      if (e.busy) check("step_idx", 32'(bus.step_idx), 32'(e.idx));
   endtask

   // Compare n queued cycles, one per clock, sampled 1 time unit after the edge.
   task automatic drain_n(input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         if (sb.size() == 0) break;
         e = sb.pop_front();
         cmp(e);
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain_all();
      drain_n(sb.size());
   endtask

   task automatic kick(input mode_t m, input int step, input int dwell, input logic [31:0] smask);
      bus.mode         = m;
      bus.step         = 6'(step);
      bus.dwell_cycles = 32'(dwell);
      bus.static_mask  = smask;
      bus.start        = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_out"}, bus.pwr_en_out, 32'h0);
      check({tag, "_busy"}, 32'(bus.busy), 32'h0);
      check({tag, "_done"}, 32'(bus.done), 32'h0);
      check({tag, "_idx"}, 32'(bus.step_idx), 32'h0);
      check({tag, "_marker"}, 32'(bus.marker), 32'h0);
   endtask

   initial begin
      bus.start = 1'b0;
      bus.abort = 1'b0;
      bus.mode = MODE_STATIC;
      bus.step = '0;
      bus.dwell_cycles = '0;
      bus.static_mask = '0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_vals("reset");
      rstn = 1'b1;
      @(posedge clk);
      #1;

      // Ramp up by 8, 4 cycles per level: 5 levels, done at T21.
      gen(MODE_RAMP_UP, 8, 4, 32'h0, 99, 1'b1);
      kick(MODE_RAMP_UP, 8, 4, 32'h0);
      drain_all();

      // Stride 12 clamps the last step at 32.
      gen(MODE_RAMP_UP, 12, 1, 32'h0, 99, 1'b1);
      kick(MODE_RAMP_UP, 12, 1, 32'h0);
      drain_all();

      // Walking one, 2 cycles per bit.
      gen(MODE_WALK, 0, 2, 32'h0, 99, 1'b1);
      kick(MODE_WALK, 0, 2, 32'h0);
      drain_all();

      // Ramp down, abort half-way through the 0x0FFFFFFF level.
      gen(MODE_RAMP_DOWN, 4, 100, 32'h0, 2, 1'b0);
      kick(MODE_RAMP_DOWN, 4, 100, 32'h0);
      drain_n(150);
      bus.abort = 1'b1;
      sb.delete();
      @(posedge clk);
      #1;
      bus.abort = 1'b0;
      repeat (3) sb.push_back(mk(32'h0, 1'b0, 1'b0, 0, exp_marker));
      drain_all();
      // Restart begins again from all-on.
      gen(MODE_RAMP_DOWN, 4, 2, 32'h0, 99, 1'b1);
      kick(MODE_RAMP_DOWN, 4, 2, 32'h0);
      drain_all();

      // Static pattern, zero dwell treated as one cycle.
      gen(MODE_STATIC, 0, 0, 32'hA5A5_A5A5, 99, 1'b1);
      kick(MODE_STATIC, 0, 0, 32'hA5A5_A5A5);
      drain_all();

      // Static rerun: a start pulse and config changes mid-run must be ignored.
      gen(MODE_STATIC, 0, 10, 32'hA5A5_A5A5, 99, 1'b1);
      kick(MODE_STATIC, 0, 10, 32'hA5A5_A5A5);
      drain_n(3);
      bus.start = 1'b1;
      bus.mode = MODE_WALK;
      bus.static_mask = 32'h0;
      bus.dwell_cycles = 32'd1;
      drain_n(1);
      bus.start = 1'b0;
      drain_all();

      // Abort on the final dwell cycle beats done.
      gen(MODE_STATIC, 0, 3, 32'h1234_5678, 1, 1'b0);
      kick(MODE_STATIC, 0, 3, 32'h1234_5678);
      drain_n(2);
      bus.abort = 1'b1;
      drain_n(1);
      bus.abort = 1'b0;
      repeat (2) sb.push_back(mk(32'h0, 1'b0, 1'b0, 0, exp_marker));
      drain_all();

      // Reset mid ramp-up.
      gen(MODE_RAMP_UP, 1, 3, 32'h0, 5, 1'b0);
      kick(MODE_RAMP_UP, 1, 3, 32'h0);
      drain_n(10);
      rstn = 1'b0;
      sb.delete();
      exp_marker = 1'b0;
      @(posedge clk);
      #1;
      check_reset_vals("midrun_reset");
      rstn = 1'b1;
      @(posedge clk);
      #1;
      check("post_reset_done", 32'(bus.done), 32'h0);

      // start together with abort in IDLE does nothing.
      bus.mode = MODE_RAMP_UP;
      bus.step = 6'd8;
      bus.dwell_cycles = 32'd4;
      bus.start = 1'b1;
      bus.abort = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      repeat (2) sb.push_back(mk(32'h0, 1'b0, 1'b0, 0, exp_marker));
      drain_all();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/pwr_en_sequencer.md
Name: pwr_en_sequencer

Overview:
Upstream controller that drives the 32-bit power-enable vector of the user DUT array. It steps through enable patterns (static mask, thermometer ramp up/down, walking one), holding each for a programmable dwell, so board power can be measured against the number of active modules. A step marker and an index are exported so scope and ADC captures can be correlated with each level.

Parameters:
NUM_MODULES, 32, width of pwr_en_out; number of DUT instances
DWELL_W, 32, width of the dwell cycle counter
IDX_W, 6, width of step_idx; must hold NUM_MODULES+1 levels

Ports:
clk100m  in  1  system clock, 100 MHz
rstn  in  1  reset; synchronous, active-low
start  in  1  single-cycle run request; sampled only in IDLE
abort  in  1  stop request; ends the run at the next edge
mode  in  2  0 STATIC, 1 RAMP_UP, 2 RAMP_DOWN, 3 WALK; latched at start
step  in  IDX_W  ramp stride in modules; latched at start
dwell_cycles  in  DWELL_W  cycles each level is held; latched at start
static_mask  in  NUM_MODULES  pattern used by STATIC; latched at start
pwr_en_out  out  NUM_MODULES  registered enable vector to the DUT array
busy  out  1  sequence running
done  out  1  one-cycle pulse on normal completion
step_idx  out  IDX_W  0-based index of the current level
marker  out  1  toggles on every level change, including the first

Behaviour:
- Reset values: pwr_en_out=0, busy=0, done=0, step_idx=0, marker=0, state IDLE. Reset mid-run aborts the run immediately and does not pulse done.
- States:
  - IDLE: start=1 and abort=0 latches config, loads the first level and enters DWELL on the same edge.
  - DWELL: counts dwell. On expiry, either advances to the next level or goes to IDLE, emitting done.
- Latency: the first level appears on pwr_en_out the cycle after start is sampled.
  - Each level is held exactly D cycles, where D = dwell_cycles, or 1 if dwell_cycles==0.
  - The cycle after the last level's dwell: pwr_en_out=0, done=1 for one cycle, busy=0.
- busy is 1 from the cycle after start through the last dwell cycle. busy and done are never 1 together.
- Level sequences (S = step, or 1 if step==0; N = NUM_MODULES):
  - STATIC: one level, mask = static_mask.
  - RAMP_UP: k = 0, S, 2S, … clamped to N. The run finishes after the level where k==N. Mask = low k bits set.
  - RAMP_DOWN: k = N, N−S, … clamped to 0. The run finishes after k==0. Mask = thermometer of k.
  - WALK: k = 0…N−1. Mask = one-hot bit k.
- Level arithmetic: the level counter is $clog2(N+1) wide. Computed k+S is compared against N before assignment, so no wrap. Subtraction saturates at 0.
- step_idx increments by 1 per level and resets to 0 at each start.
- marker toggles on the edge that loads every new level.
- abort:
  - In DWELL: next edge gives pwr_en_out=0, IDLE, busy=0, no done.
  - In IDLE: ignored, and it suppresses a simultaneous start.
- start while busy is ignored.
- Changes on config inputs during a run have no effect.
- done and abort on the same final cycle: abort wins, no done.

Decomposition:
- Package pwr_seq_pkg holds:
  - the mode encoding constants (MODE_STATIC, MODE_RAMP_UP, MODE_RAMP_DOWN, MODE_WALK);
  - the state enum (IDLE, DWELL);
  - NUM_MODULES_DEFAULT.
- One combinational sub-module, pwr_mask_gen (mode, level, static_mask → mask), isolates thermometer and one-hot generation. The sequencer registers its output.

Test Plan:
- RAMP_UP, step=8, dwell=4, start at T0:
  - pwr_en_out is 0x00000000 T1–T4, 0x000000FF T5–T8, 0x0000FFFF T9–T12, 0x00FFFFFF T13–T16, 0xFFFFFFFF T17–T20.
  - At T21: out=0, done=1. step_idx runs 0→4; marker toggles 5 times.
- RAMP_UP, step=12, dwell=1 (clamp): levels are 0x0, 0xFFF, 0xFFFFFF, 0xFFFFFFFF, one cycle each, then done. Level k never exceeds 32.
- WALK, dwell=2: 0x1 for 2 cycles, 0x2 for 2 cycles, … 0x80000000. done arrives 65 cycles after start; step_idx reaches 31.
- RAMP_DOWN, step=4, dwell=100, abort at level 0x0FFFFFFF: next cycle out=0 and busy=0, with no done pulse ever. A following start restarts from 0xFFFFFFFF.
- STATIC, mask=0xA5A5A5A5, dwell=0:
  - Output is held exactly 1 cycle, then done.
  - A start pulse while busy (dwell=10 rerun) is ignored.
  - Changing mode mid-run has no effect.
- rstn low mid-RAMP_UP: next cycle all outputs are at reset values. start and abort asserted together in IDLE: no run, busy stays 0.
